load_return_unit: RTL

Parametrised in-order load-return stage placed between the data-memory response port and the writeback register. It queues up to DEPTH outstanding load descriptors and pairs each with its memory response. It performs byte/halfword/word extraction with sign or zero extension, LWL/LWR merging and misalignment detection, then presents the result through a registered valid/ready output. Pipeline flush is supported: responses still in flight for flushed loads are discarded.

---
 rtl/load_return_unit_pkg.sv | 25 ++
 rtl/load_return_unit_extract.sv | 50 +++++
 rtl/load_return_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/load_return_unit_pkg.sv
// Shared definitions for the load-return path: MIPS load opcodes and the
// address-alignment rule applied when a load descriptor is queued.
package load_return_unit_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;

    // LWL/LWR are unaligned by design and never fault; bytes cannot misalign.
    function automatic logic addr_fault(input logic [5:0] op, input logic [1:0] addr);
        logic fault;
        fault = 1'b0;
        case (op)
            OP_LW:         fault = (addr != 2'b00);
            OP_LH, OP_LHU: fault = addr[0];
            default:       fault = 1'b0;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/load_return_unit_extract.sv
// Combinational load data shaper: byte/halfword extraction with sign or zero
// extension and LWL/LWR merging against the old register value.
module load_extract
    import load_return_unit_pkg::*;
#(
    parameter int UNALIGNED_EN = 1
) (
    input  logic [5:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    input  logic [31:0] old,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lwl_merge;
    logic [31:0] lwr_merge;

    always_comb begin
        byte_sel = word[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? word[31:16] : word[15:0];

        case (addr)
            2'd0:    lwl_merge = {word[7:0],  old[23:0]};
            2'd1:    lwl_merge = {word[15:0], old[15:0]};
            2'd2:    lwl_merge = {word[23:0], old[7:0]};
            default: lwl_merge = word;
        endcase

        case (addr)
            2'd0:    lwr_merge = word;
            2'd1:    lwr_merge = {old[31:24], word[31:8]};
            2'd2:    lwr_merge = {old[31:16], word[31:16]};
            default: lwr_merge = {old[31:8],  word[31:24]};
        endcase

        result = word;
        case (op)
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'h0, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'h0, half_sel};
            OP_LWL:  result = (UNALIGNED_EN != 0) ? lwl_merge : word;
            OP_LWR:  result = (UNALIGNED_EN != 0) ? lwr_merge : word;
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_return_unit.sv
// In-order load-return stage: queues load descriptors, pairs them with memory
// responses, shapes the data and presents it through a registered output slot.
module load_return_unit
    import load_return_unit_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int TAG_W        = 5,
    parameter int UNALIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_op,
    input  logic [1:0]       req_addr,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [31:0]      req_old,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [31:0]      rsp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_exc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [5:0]       op;
        logic [1:0]       addr;
        logic [TAG_W-1:0] tag;
        logic [31:0]      old;
        logic             exc;
    } entry_t;

    entry_t           queue_mem [DEPTH];
    logic [PTR_W-1:0] head_ptr_reg, tail_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] pend_cnt_reg, pend_cnt_next;
    logic [CNT_W-1:0] discard_cnt_reg, discard_cnt_next;

    entry_t      head;
    entry_t      new_entry;
    logic        head_valid;
    logic        slot_free;
    logic        push;
    logic        pop;
    logic        rsp_fire;
    logic [31:0] ext_result;

    assign head       = queue_mem[head_ptr_reg];
    assign head_valid = (count_reg != '0);
    assign slot_free  = !out_valid || out_ready;

    assign new_entry.op   = req_op;
    assign new_entry.addr = req_addr;
    assign new_entry.tag  = req_tag;
    assign new_entry.old  = req_old;
    assign new_entry.exc  = addr_fault(req_op, req_addr);

    assign req_ready = (count_reg != FULL_CNT) && (discard_cnt_reg == '0) && !flush;
    assign rsp_ready = flush || (discard_cnt_reg != '0) ||
                       (head_valid && !head.exc && slot_free);

    assign push     = req_valid && req_ready;
    assign rsp_fire = rsp_valid && rsp_ready;
    // The queue is always empty while discarding, so head_valid alone gates completion.
    assign pop      = !flush && head_valid && slot_free && (head.exc || rsp_valid);

    load_extract #(
        .UNALIGNED_EN(UNALIGNED_EN)
    ) u_extract (
        .op    (head.op),
        .addr  (head.addr),
        .word  (rsp_data),
        .old   (head.old),
        .result(ext_result)
    );

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        pend_cnt_next = pend_cnt_reg;
        case ({push && !new_entry.exc, pop && !head.exc})
            2'b10:   pend_cnt_next = pend_cnt_reg + 1'b1;
            2'b01:   pend_cnt_next = pend_cnt_reg - 1'b1;
            default: pend_cnt_next = pend_cnt_reg;
        endcase

        // A response taken during the flush cycle belongs to a load being dropped.
        discard_cnt_next = discard_cnt_reg;
        if (flush) begin
            discard_cnt_next = discard_cnt_reg + pend_cnt_reg;
            if (rsp_fire && (discard_cnt_next != '0))
                discard_cnt_next = discard_cnt_next - 1'b1;
        end else if ((discard_cnt_reg != '0) && rsp_fire) begin
            discard_cnt_next = discard_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            queue_mem[tail_ptr_reg] <= new_entry;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_ptr_reg    <= '0;
            tail_ptr_reg    <= '0;
            count_reg       <= '0;
            pend_cnt_reg    <= '0;
            discard_cnt_reg <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_tag         <= '0;
            out_exc         <= 1'b0;
        end else begin
            discard_cnt_reg <= discard_cnt_next;
            if (flush) begin
                head_ptr_reg <= '0;
                tail_ptr_reg <= '0;
                count_reg    <= '0;
                pend_cnt_reg <= '0;
                out_valid    <= 1'b0;
            end else begin
                if (push)
                    tail_ptr_reg <= tail_ptr_reg + 1'b1;
                if (pop)
                    head_ptr_reg <= head_ptr_reg + 1'b1;
                count_reg    <= count_next;
                pend_cnt_reg <= pend_cnt_next;
                if (pop) begin
                    out_valid <= 1'b1;
                    out_data  <= head.exc ? 32'h0 : ext_result;
                    out_tag   <= head.tag;
                    out_exc   <= head.exc;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
